// File: rtl/reg_fetch_stage.sv
// reg_fetch_stage: operand-fetch stage feeding the ALU.
//   Holds the 32x32 general register file (x0 hard-wired to zero) and resolves
//   both source operands through a two-port bypass network and a write-back
//   write-through path. Decode info, PC and operands are captured into a
//   single-entry valid/ready slot. Sources that depend on unfinished writers
//   interlock the stage.
//
// Configuration macro: RF_BYPASS_EN
//   defined   - bypass ports forward their data; only pending writers stall.
//   undefined - bypass data is never forwarded; any used source matching a
//               valid bypass port stalls until the value reaches WB or the RF.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   flush_i                     kill held entry, refuse input this cycle
//   valid_i / ready_o           upstream handshake
//   decode_info_i, pc_i         instruction payload
//   rs_idx_i, rs_used_i         source indices ([0]=rj, [1]=rk/rd) and use flags
//   byp_valid_i/idx_i/pending_i/data_i
//                               in-flight writers, port 0 is the younger
//   wb_we_i, wb_idx_i, wb_data_i write-back port
//   valid_o / ready_i           downstream handshake
//   decode_info_o, pc_o, reg_fetch_o
//                               registered payload and operands

package reg_fetch_stage_pkg;

    // Decoded instruction payload carried to the ALU.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        rd_we;
        logic [13:0] imm;
    } decode_info_t;

endpackage

module reg_fetch_stage
    import reg_fetch_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  decode_info_t         decode_info_i,
    input  logic [31:0]          pc_i,
    input  logic [1:0][4:0]      rs_idx_i,
    input  logic [1:0]           rs_used_i,
    input  logic [1:0]           byp_valid_i,
    input  logic [1:0][4:0]      byp_idx_i,
    input  logic [1:0]           byp_pending_i,
    input  logic [1:0][31:0]     byp_data_i,
    input  logic                 wb_we_i,
    input  logic [4:0]           wb_idx_i,
    input  logic [31:0]          wb_data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output decode_info_t         decode_info_o,
    output logic [31:0]          pc_o,
    output logic [1:0][31:0]     reg_fetch_o
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned NUM_SRC  = 2;

    // Register file
    logic [NUM_REGS-1:0][XLEN-1:0] rf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_q <= '0;
        end else if (wb_we_i && (wb_idx_i != REG_AW'(0))) begin
            rf_q[wb_idx_i] <= wb_data_i;
        end
    end

    // Per-source match flags
    logic [NUM_SRC-1:0] nz_c;
    logic [NUM_SRC-1:0] hit0_c;
    logic [NUM_SRC-1:0] hit1_c;
    logic [NUM_SRC-1:0] wb_hit_c;

    always_comb begin
        nz_c     = '0;
        hit0_c   = '0;
        hit1_c   = '0;
        wb_hit_c = '0;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            nz_c[s]     = (rs_idx_i[s] != REG_AW'(0));
            hit0_c[s]   = byp_valid_i[0] && (byp_idx_i[0] == rs_idx_i[s]);
            hit1_c[s]   = byp_valid_i[1] && (byp_idx_i[1] == rs_idx_i[s]);
            wb_hit_c[s] = wb_we_i && (wb_idx_i == rs_idx_i[s]);
        end
    end

    // Operand select and hazard detection; later assignments take priority
    logic [NUM_SRC-1:0][XLEN-1:0] opnd_c;
    logic [NUM_SRC-1:0]           haz_c;

    always_comb begin
        opnd_c = '0;
        haz_c  = '0;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            opnd_c[s] = rf_q[rs_idx_i[s]];
            if (wb_hit_c[s]) begin
                opnd_c[s] = wb_data_i;
            end
`ifdef RF_BYPASS_EN
            if (hit1_c[s]) begin
                opnd_c[s] = byp_data_i[1];
            end
            if (hit0_c[s]) begin
                opnd_c[s] = byp_data_i[0];
            end
            // Only the youngest matching writer decides: a ready port 0 shadows a pending port 1.
            haz_c[s] = rs_used_i[s] && nz_c[s] &&
                       (hit0_c[s] ? byp_pending_i[0] : (hit1_c[s] && byp_pending_i[1]));
`else
            haz_c[s] = rs_used_i[s] && nz_c[s] && (hit0_c[s] || hit1_c[s]);
`endif
            if (!nz_c[s]) begin
                opnd_c[s] = '0;
            end
        end
    end

`ifndef RF_BYPASS_EN
    // Bypass data/pending are not consumed when forwarding is disabled.
    logic unused_byp_c;
    assign unused_byp_c = ^{byp_data_i, byp_pending_i};
`endif

    // Handshake
    logic stall_c;
    logic accept_c;
    logic valid_q;

    assign stall_c  = |haz_c;
    assign ready_o  = !flush_i && !stall_c && (!valid_q || ready_i);
    assign accept_c = valid_i && ready_o;

    // Output slot
    logic                         valid_d;
    decode_info_t                 dec_q,  dec_d;
    logic [XLEN-1:0]              pc_q,   pc_d;
    logic [NUM_SRC-1:0][XLEN-1:0] opnd_q, opnd_d;

    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        pc_d    = pc_q;
        opnd_d  = opnd_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept_c) begin
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
        if (accept_c) begin
            dec_d  = decode_info_i;
            pc_d   = pc_i;
            opnd_d = opnd_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            pc_q    <= '0;
            opnd_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
            pc_q    <= pc_d;
            opnd_q  <= opnd_d;
        end
    end

    assign valid_o       = valid_q;
    assign decode_info_o = dec_q;
    assign pc_o          = pc_q;
    assign reg_fetch_o   = opnd_q;

endmodule

// File: tb/tb_reg_fetch_stage.sv
// tb_reg_fetch_stage: directed scenarios plus randomized traffic for
// reg_fetch_stage, checked against a behavioural model of the register file,
// operand resolution rules and output slot.
module tb_reg_fetch_stage;
    import reg_fetch_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    decode_info_t      decode_info_i;
    logic [31:0]       pc_i;
    logic [1:0][4:0]   rs_idx_i;
    logic [1:0]        rs_used_i;
    logic [1:0]        byp_valid_i;
    logic [1:0][4:0]   byp_idx_i;
    logic [1:0]        byp_pending_i;
    logic [1:0][31:0]  byp_data_i;
    logic              wb_we_i;
    logic [4:0]        wb_idx_i;
    logic [31:0]       wb_data_i;
    logic              valid_o;
    logic              ready_i;
    decode_info_t      decode_info_o;
    logic [31:0]       pc_o;
    logic [1:0][31:0]  reg_fetch_o;

    always #5 clk = ~clk;

    reg_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .decode_info_i (decode_info_i),
        .pc_i          (pc_i),
        .rs_idx_i      (rs_idx_i),
        .rs_used_i     (rs_used_i),
        .byp_valid_i   (byp_valid_i),
        .byp_idx_i     (byp_idx_i),
        .byp_pending_i (byp_pending_i),
        .byp_data_i    (byp_data_i),
        .wb_we_i       (wb_we_i),
        .wb_idx_i      (wb_idx_i),
        .wb_data_i     (wb_data_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .decode_info_o (decode_info_o),
        .pc_o          (pc_o),
        .reg_fetch_o   (reg_fetch_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0]  m_rf [32];
    logic         m_valid;
    logic [31:0]  m_pc;
    logic [31:0]  m_dec;
    logic [31:0]  m_op  [2];
    logic         e_ready;
    logic [31:0]  e_op  [2];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_valid = 1'b0;
        m_pc    = 32'h0;
        m_dec   = 32'h0;
        m_op[0] = 32'h0;
        m_op[1] = 32'h0;
    endtask

    // Value and interlock for one source, from the operand rules.
    task automatic model_src(input int s, output logic [31:0] d, output logic h);
        int  w;
        logic [4:0] idx;
        idx = rs_idx_i[s];
        d = 32'h0;
        h = 1'b0;
        if (idx != 5'd0) begin
            w = -1;
            for (int p = 1; p >= 0; p--)
                if (byp_valid_i[p] && byp_idx_i[p] == idx) w = p;
            d = (wb_we_i && wb_idx_i == idx) ? wb_data_i : m_rf[idx];
`ifdef RF_BYPASS_EN
            if (w >= 0) begin
                d = byp_data_i[w];
                h = rs_used_i[s] && byp_pending_i[w];
            end
`else
            h = rs_used_i[s] && (w >= 0);
`endif
        end
    endtask

    task automatic model_comb();
        logic h0, h1;
        model_src(0, e_op[0], h0);
        model_src(1, e_op[1], h1);
        e_ready = !flush_i && !(h0 || h1) && (!m_valid || ready_i);
    endtask

    task automatic model_edge();
        logic acc;
        acc = valid_i && e_ready;
        if (acc) begin
            m_pc    = pc_i;
            m_dec   = 32'(decode_info_i);
            m_op[0] = e_op[0];
            m_op[1] = e_op[1];
        end
        if (flush_i)      m_valid = 1'b0;
        else if (acc)     m_valid = 1'b1;
        else if (ready_i) m_valid = 1'b0;
        if (wb_we_i && wb_idx_i != 5'd0) m_rf[wb_idx_i] = wb_data_i;
    endtask

    task automatic check_outputs();
        check("valid_o", 64'(valid_o), 64'(m_valid));
        check("pc_o",    64'(pc_o),    64'(m_pc));
        check("dec_o",   64'(32'(decode_info_o)), 64'(m_dec));
        check("op0",     64'(reg_fetch_o[0]), 64'(m_op[0]));
        check("op1",     64'(reg_fetch_o[1]), 64'(m_op[1]));
    endtask

    // One clock: inputs already driven after a falling edge.
    task automatic cycle();
        #1;
        model_comb();
        check("ready_o", 64'(ready_o), 64'(e_ready));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        flush_i       = 1'b0;
        valid_i       = 1'b0;
        ready_i       = 1'b1;
        decode_info_i = '0;
        pc_i          = 32'h0;
        rs_idx_i      = '0;
        rs_used_i     = 2'b00;
        byp_valid_i   = 2'b00;
        byp_idx_i     = '0;
        byp_pending_i = 2'b00;
        byp_data_i    = '0;
        wb_we_i       = 1'b0;
        wb_idx_i      = 5'd0;
        wb_data_i     = 32'h0;
    endtask

    task automatic rand_inputs();
        flush_i       = ($urandom_range(0, 99) < 8);
        valid_i       = ($urandom_range(0, 3) != 0);
        ready_i       = ($urandom_range(0, 99) < 70);
        decode_info_i = decode_info_t'($urandom);
        pc_i          = $urandom;
        for (int s = 0; s < 2; s++) begin
            rs_idx_i[s]      = 5'($urandom_range(0, 7));
            byp_idx_i[s]     = 5'($urandom_range(0, 7));
            byp_valid_i[s]   = ($urandom_range(0, 99) < 35);
            byp_pending_i[s] = ($urandom_range(0, 99) < 30);
            byp_data_i[s]    = $urandom;
        end
        rs_used_i = 2'($urandom);
        wb_we_i   = ($urandom_range(0, 1) == 1);
        wb_idx_i  = 5'($urandom_range(0, 7));
        wb_data_i = $urandom;
    endtask

    initial begin
        logic [31:0] held_pc;
        idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 64'(ready_o), 64'(1));
        check_outputs();

        // Write x5 then read it back through rj
        wb_we_i = 1'b1; wb_idx_i = 5'd5; wb_data_i = 32'h1234;
        cycle();
        idle();
        valid_i = 1'b1; rs_idx_i[0] = 5'd5; rs_idx_i[1] = 5'd0; rs_used_i = 2'b11; pc_i = 32'h100;
        cycle();
        check("x5_op0",   64'(reg_fetch_o[0]), 64'(32'h1234));
        check("x5_op1",   64'(reg_fetch_o[1]), 64'(0));
        check("x5_valid", 64'(valid_o), 64'(1));

        // x0 source with a pending bypass to index 0 does not stall
        idle();
        valid_i = 1'b1; rs_used_i = 2'b01;
        byp_valid_i = 2'b01; byp_pending_i = 2'b01; byp_data_i[0] = 32'hDEAD;
        cycle();
        check("x0_valid", 64'(valid_o), 64'(1));
        check("x0_op0",   64'(reg_fetch_o[0]), 64'(0));

        // Unused source matching a pending writer does not stall
        idle();
        valid_i = 1'b1; rs_idx_i[0] = 5'd7; rs_used_i = 2'b00; pc_i = 32'h120;
        byp_valid_i = 2'b01; byp_idx_i[0] = 5'd7; byp_pending_i = 2'b01;
        cycle();
        check("unused_pc", 64'(pc_o), 64'(32'h120));

        // Pending writer on a used source stalls
        rs_used_i = 2'b01; pc_i = 32'h140;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("x7_stall", 64'(ready_o), 64'(0));
        end
        byp_pending_i = 2'b00; byp_data_i[0] = 32'h55;
        cycle();
`ifdef RF_BYPASS_EN
        check("x7_valid", 64'(valid_o), 64'(1));
        check("x7_op0",   64'(reg_fetch_o[0]), 64'(32'h55));
`else
        check("x7_nofwd", 64'(valid_o), 64'(0));
`endif

        // Hold with ready_i low while inputs change
        idle();
        valid_i = 1'b1; pc_i = 32'hA0;
        cycle();
        held_pc = 32'hA0;
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            ready_i = 1'b0; flush_i = 1'b0; valid_i = 1'b1;
            cycle();
            check("hold_pc", 64'(pc_o), 64'(held_pc));
        end
        idle();
        valid_i = 1'b1; pc_i = 32'hB0;
        cycle();
        check("reload_pc",    64'(pc_o), 64'(32'hB0));
        check("reload_valid", 64'(valid_o), 64'(1));

        // Flush kills the slot and refuses the input
        flush_i = 1'b1; pc_i = 32'hC0; ready_i = 1'b0;
        cycle();
        check("flush_valid", 64'(valid_o), 64'(0));
        check("flush_pc",    64'(pc_o), 64'(32'hB0));

        // Reset in the middle of a hold
        idle();
        valid_i = 1'b1; pc_i = 32'hD0;
        cycle();
        ready_i = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid", 64'(valid_o), 64'(0));
        check("arst_pc",    64'(pc_o), 64'(0));
        check("arst_op0",   64'(reg_fetch_o[0]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_fetch_stage.md
# reg_fetch_stage

Operand-fetch stage directly upstream of the ALU: holds the 32×32 general register file and resolves both source operands through a two-port bypass network plus a write-back write-through path. It registers decode info, PC and the two fetched operands into a single-entry valid/ready pipeline slot whose outputs drive the ALU's `decode_info_i`, `pc_i` and `reg_fetch_i`. It interlocks on operands that are not yet available.

## Interface
- No parameters; widths fixed (32-bit data, 5-bit register index).
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous reset, active low.
- `flush_i` in 1: kill the held entry and refuse input this cycle.
- `valid_i` in 1: upstream entry valid.
- `ready_o` out 1: stage accepts an entry this cycle.
- `decode_info_i` in `decode_info_t`: decoded instruction.
- `pc_i` in 32: instruction PC.
- `rs_idx_i` in [1:0][4:0]: source indices; [0] becomes the rj operand, [1] the rk/rd operand.
- `rs_used_i` in [1:0]: source actually read; an unused source never causes a stall.
- `byp_valid_i` in [1:0]: bypass port carries an in-flight writer; port 0 is the younger writer.
- `byp_idx_i` in [1:0][4:0]: destination index of the writer.
- `byp_pending_i` in [1:0]: writer's data not yet produced (load, multi-cycle op).
- `byp_data_i` in [1:0][31:0]: writer's result, meaningful when not pending.
- `wb_we_i` in 1: write-back enable.
- `wb_idx_i` in 5: write-back index.
- `wb_data_i` in 32: write-back data.
- `valid_o` out 1: output entry valid.
- `ready_i` in 1: ALU/EX consumes the entry.
- `decode_info_o` out `decode_info_t`: registered decode info.
- `pc_o` out 32: registered PC.
- `reg_fetch_o` out [1:0][31:0]: registered operands.

## Operation
- Register file: 32 entries. x0 reads 0 and writes to index 0 are dropped. Reset clears all entries to 0. Write occurs on the rising edge when `wb_we_i`.
- Per-source operand select, highest priority first:
  - idx 0 → 0;
  - bypass port 0 match (`byp_valid_i[0]` and idx equal);
  - bypass port 1 match;
  - WB match (`wb_we_i` and idx equal, write-through);
  - register file.
- Hazard per source: `rs_used_i` set, idx ≠ 0, and the highest-priority matching bypass port has `byp_pending_i` set. A pending match on port 1 that is shadowed by a non-pending match on port 0 is not a hazard.
- `stall` = hazard on either source.
- `ready_o` = `!flush_i && !stall && (!valid_o || ready_i)`.
- Accept (`valid_i && ready_o`): capture `decode_info_i`, `pc_i` and the selected operands. Operands are sampled only at acceptance; while stalled they are re-selected every cycle.
- Output slot:
  - `flush_i` → `valid_o` ← 0 (overrides everything);
  - else accept → `valid_o` ← 1;
  - else `ready_i` → `valid_o` ← 0;
  - else hold.
- Data outputs stay stable while `valid_o && !ready_i`.
- `ready_o` never depends combinationally on `valid_i`.

## Timing
- Reset: `valid_o`=0, `decode_info_o`=0, `pc_o`=0, `reg_fetch_o`=0, all registers 0. `ready_o` is 1 after reset, unless a hazard is present.
- Latency: 1 cycle from accept to `valid_o`. Throughput: 1 entry/cycle with `ready_i` held high.
- Simultaneous `valid_o && ready_i` and a new accept: the slot reloads in the same edge with no bubble.
- WB to the same index being read in the same cycle returns `wb_data_i`.
- Reset asserted mid-stall or mid-hold: slot and register file clear immediately; no entry survives.
- Flush in the same cycle as `valid_i`: the entry is not accepted, and upstream keeps it or flushes it itself.

## Configuration
- `RF_BYPASS_EN` defined: bypass ports select data as above.
- Undefined: bypass data is never selected. Any `rs_used_i` source (idx ≠ 0) matching a valid bypass port stalls regardless of `byp_pending_i`, until the value arrives via WB write-through or the register file. Port widths are unchanged.

## Test plan
- Reset, then `wb` write x5=0x1234, then accept `rs_idx`={5,0} → `reg_fetch_o`={0x1234,0} one cycle later, `valid_o`=1.
- x3=0x10 in the file, bypass0 {x3, 0xAA, not pending}, bypass1 {x3, 0xBB} → operand 0xAA with `RF_BYPASS_EN`. Without the macro, `ready_o`=0 until bypass valid drops and WB writes x3.
- Bypass0 {x7, pending} for 3 cycles, source x7 used → `ready_o`=0 for those 3 cycles. Pending drops with data 0x55 → accepted, operand 0x55.
- Same x7 pending match but `rs_used_i`=0 → no stall; x0 source with bypass idx 0 pending → no stall, operand 0.
- `valid_o`=1, `ready_i`=0 for 4 cycles with changing inputs → outputs unchanged. `ready_i`=1 with `valid_i`=1 → back-to-back reload, no bubble.
- `flush_i` with `valid_o`=1 and `valid_i`=1 → next cycle `valid_o`=0 and the input is not accepted. `rst_n` low mid-hold → outputs 0 asynchronously.
